ars_pm_out_serializer: RTL

ARS_PM_OUT_SERIALIZER -- requirements
Module: ars_pm_out_serializer

---
 rtl/ars_pm_out_serializer_if.sv | 24 ++
 rtl/ars_pm_out_serializer.sv | 106 ++++++++++
 2 files changed

// File: rtl/ars_pm_out_serializer_if.sv
// Handshake bundle between the point-multiply core, the serializer and the word sink.
// The slave modport is the serializer's view; master is the driver/sink side.
interface ars_pm_out_serializer_if;
   logic [232:0] DINx;
   logic [232:0] DINy;
   logic         PM_VALID;
   logic [31:0]  DOUT;
   logic         DOUT_VALID;
   logic         DOUT_READY;
   logic [4:0]   DOUT_IDX;
   logic         DOUT_LAST;
   logic         BUSY;
   logic         OVERRUN;

   modport slave (
      input  DINx, DINy, PM_VALID, DOUT_READY,
      output DOUT, DOUT_VALID, DOUT_IDX, DOUT_LAST, BUSY, OVERRUN
   );

   modport master (
      output DINx, DINy, PM_VALID, DOUT_READY,
      input  DOUT, DOUT_VALID, DOUT_IDX, DOUT_LAST, BUSY, OVERRUN
   );
endinterface

// File: rtl/ars_pm_out_serializer.sv
// Streams a captured 233-bit (x, y) point as 16 LS-first 32-bit words over a valid/ready link.
// Define ARS_SER_CHECKSUM_EN to append a 17th word holding the XOR of words 0..15.
module ars_pm_out_serializer (
   input  logic                          CLK,
   input  logic                          RST_N,
   ars_pm_out_serializer_if.slave        bus
);

`ifdef ARS_SER_CHECKSUM_EN
   localparam logic [4:0] LAST_IDX = 5'd16;
   typedef enum logic [1:0] {IDLE, SEND, CHK} state_e;
`else
   localparam logic [4:0] LAST_IDX = 5'd15;
   typedef enum logic [1:0] {IDLE, SEND} state_e;
`endif

   state_e        state_q;
   logic [232:0]  x_q, y_q;
   logic [4:0]    idx_q, idx_d;
   logic [31:0]   dout_q, word_d;
   logic          dout_valid_q, dout_last_q, overrun_q;
`ifdef ARS_SER_CHECKSUM_EN
   logic [31:0]   chk_q;
`endif

   logic transfer, final_xfer, start_frame;

   function automatic logic [31:0] word_of(input logic [232:0] x, input logic [232:0] y,
                                           input logic [3:0] k);
      logic [255:0] x_ext, y_ext;
      x_ext = {23'b0, x};
      y_ext = {23'b0, y};
      if (!k[3]) word_of = x_ext[{k[2:0], 5'd0} +: 32];
      else       word_of = y_ext[{k[2:0], 5'd0} +: 32];
   endfunction

   // A new frame may start from IDLE or on the very edge the final word leaves.
   // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
   always_comb begin
      transfer    = dout_valid_q & bus.DOUT_READY;
      final_xfer  = transfer & (idx_q == LAST_IDX);
      start_frame = bus.PM_VALID & ((state_q == IDLE) | final_xfer);
      idx_d       = idx_q + 5'd1;
      word_d      = word_of(x_q, y_q, idx_d[3:0]);
   end

   // NOTE: the operand registers are ordinary flops (not a RAM), so they take the reset like any other state.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         idx_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef ARS_SER_CHECKSUM_EN
         chk_q        <= '0;
`endif
      end else begin
         if (bus.PM_VALID && (state_q != IDLE) && !final_xfer) overrun_q <= 1'b1;

         if (start_frame) begin
            state_q      <= SEND;
            x_q          <= bus.DINx;
            y_q          <= bus.DINy;
            idx_q        <= '0;
            dout_q       <= bus.DINx[31:0];
            dout_valid_q <= 1'b1;
            dout_last_q  <= 1'b0;
`ifdef ARS_SER_CHECKSUM_EN
            chk_q        <= '0;
`endif
         end else if (final_xfer) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
         end else if (transfer) begin
`ifdef ARS_SER_CHECKSUM_EN
            chk_q <= chk_q ^ dout_q;
            if (idx_q == 5'd15) begin
               state_q <= CHK;
               dout_q  <= chk_q ^ dout_q;
            end else begin
               dout_q  <= word_d;
            end
`else
            dout_q <= word_d;
`endif
            idx_q       <= idx_d;
            dout_last_q <= (idx_d == LAST_IDX);
         end
      end
   end

   assign bus.DOUT       = dout_q;
   assign bus.DOUT_VALID = dout_valid_q;
   assign bus.DOUT_IDX   = idx_q;
   assign bus.DOUT_LAST  = dout_last_q;
   assign bus.BUSY       = (state_q != IDLE);
   assign bus.OVERRUN    = overrun_q;

endmodule
